pixel_block_feeder: RTL and testbench



---
 rtl/pixel_block_feeder.sv | 193 +++++++++++++++++++
 tb/tb_pixel_block_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_block_feeder.sv
// pixel_block_feeder
//   Collects a raster stream of unsigned pixels into 8x8 blocks held in a
//   two-bank (ping-pong) buffer, then streams each full block out as
//   level-shifted (pixel - 128) two's-complement words for the converter.
//   Optional macro PIXEL_FEEDER_TRANSPOSE_EN: read each block column-major
//   (transposed) instead of raster order.
module pixel_block_feeder #(
    parameter int PIX_W    = 8,
    parameter int OUT_W    = 25,
    parameter int BLK_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int CNT_W = 2 * BLK_LOG2;
    localparam int DEPTH = 1 << CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Bank index is the MSB of the address; the block offset fills the rest.
    logic [PIX_W-1:0] mem_r [0:2*DEPTH-1];

    logic [1:0]       full_r;
    logic             wr_bank_r;
    logic             rd_bank_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [0:0]       state_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [OUT_W-1:0] out_data_r;

    logic             in_ready_s;
    logic             in_acc_s;
    logic             out_acc_s;
    logic             wr_done_s;
    logic             rd_release_s;
    logic             load_s;
    logic             load_bank_s;
    logic [CNT_W-1:0] rd_cnt_nxt_s;
    logic             rd_bank_nxt_s;
    logic [0:0]       state_nxt_s;
    logic             out_valid_nxt_s;
    logic             out_last_nxt_s;
    logic [OUT_W-1:0] out_data_nxt_s;
    logic [PIX_W-1:0] load_pix_s;
    logic [1:0]       full_set_s;
    logic [1:0]       full_clr_s;

    // Map the read sequence number to a storage offset within the block.
    function automatic logic [CNT_W-1:0] rd_addr_f(input logic [CNT_W-1:0] idx);
`ifdef PIXEL_FEEDER_TRANSPOSE_EN
        return {idx[BLK_LOG2-1:0], idx[CNT_W-1:BLK_LOG2]};
`else
        return idx;
`endif
    endfunction

    // Subtract the mid-scale offset and sign-extend to the converter width.
    function automatic logic [OUT_W-1:0] level_shift_f(input logic [PIX_W-1:0] pix);
        logic [PIX_W:0] diff;
        diff = {1'b0, pix} - {2'b01, {(PIX_W-1){1'b0}}};
        return {{(OUT_W-PIX_W-1){diff[PIX_W]}}, diff};
    endfunction

    assign in_ready_s = !rst && !full_r[wr_bank_r];
    assign in_acc_s   = in_valid && in_ready_s;
    assign out_acc_s  = out_valid_r && out_ready;
    assign wr_done_s  = in_acc_s && (wr_cnt_r == CNT_MAX);

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

    // Read FSM next-state: decide what (if anything) loads into the output register.
    always_comb begin
        state_nxt_s     = state_r;
        rd_cnt_nxt_s    = rd_cnt_r;
        rd_bank_nxt_s   = rd_bank_r;
        out_valid_nxt_s = out_valid_r;
        load_s          = 1'b0;
        load_bank_s     = rd_bank_r;
        rd_release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (full_r[rd_bank_r]) begin
                    load_s          = 1'b1;
                    rd_cnt_nxt_s    = CNT_ZERO;
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_STREAM;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            ST_STREAM: begin
                if (out_acc_s) begin
                    if (rd_cnt_r != CNT_MAX) begin
                        load_s       = 1'b1;
                        rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
                    end else begin
                        // Block finished: hand the bank back to the writer.
                        rd_release_s  = 1'b1;
                        rd_bank_nxt_s = !rd_bank_r;
                        rd_cnt_nxt_s  = CNT_ZERO;
                        if (full_r[!rd_bank_r]) begin
                            load_s      = 1'b1;
                            load_bank_s = !rd_bank_r;
                        end else begin
                            out_valid_nxt_s = 1'b0;
                            state_nxt_s     = ST_IDLE;
                        end
                    end
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    assign load_pix_s = mem_r[{load_bank_s, rd_addr_f(rd_cnt_nxt_s)}];

    // Output register next values: reload on load, clear when going idle, else hold.
    always_comb begin
        out_data_nxt_s = out_data_r;
        out_last_nxt_s = out_last_r;
        if (load_s) begin
            out_data_nxt_s = level_shift_f(load_pix_s);
            out_last_nxt_s = (rd_cnt_nxt_s == CNT_MAX);
        end else if (!out_valid_nxt_s) begin
            out_last_nxt_s = 1'b0;
        end else begin
            out_last_nxt_s = out_last_r;
        end
    end

    // Full flags: writer sets its bank, reader clears its bank; never the same bank.
    assign full_set_s = wr_done_s    ? (2'b01 << wr_bank_r) : 2'b00;
    assign full_clr_s = rd_release_s ? (2'b01 << rd_bank_r) : 2'b00;

    // Pixel storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_acc_s) begin
            mem_r[{wr_bank_r, wr_cnt_r}] <= in_pixel;
        end
    end

    // Control and output state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r      <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_cnt_r    <= CNT_ZERO;
            rd_cnt_r    <= CNT_ZERO;
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
        end else begin
            full_r      <= (full_r | full_set_s) & ~full_clr_s;
            rd_bank_r   <= rd_bank_nxt_s;
            rd_cnt_r    <= rd_cnt_nxt_s;
            state_r     <= state_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_data_r  <= out_data_nxt_s;
            if (in_acc_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
                if (wr_cnt_r == CNT_MAX) begin
                    wr_bank_r <= !wr_bank_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_block_feeder.sv
// Scoreboard bench for pixel_block_feeder: the stimulus side pushes the
// expected output words for each completed block; a negedge monitor compares
// every presented word against the queue head and pops on handshake.
module tb_pixel_block_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_data;
    logic        out_last;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    logic [7:0]  pend_q[$];
    logic [25:0] exp_q[$];   // {last, data}

    always #5 clk = ~clk;

    pixel_block_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    function automatic logic [24:0] shift_model(input logic [7:0] p);
        logic signed [24:0] v;
        v = $signed({17'd0, p}) - 25'sd128;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Record an accepted pixel; on block completion queue its 64 output words.
    task automatic model_accept(input logic [7:0] p);
        logic [5:0] kk;
        logic [5:0] a;
        pend_q.push_back(p);
        if (pend_q.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
                kk = k[5:0];
`ifdef PIXEL_FEEDER_TRANSPOSE_EN
                a = {kk[2:0], kk[5:3]};
`else
                a = kk;
`endif
                exp_q.push_back({(kk == 6'd63), shift_model(pend_q[a])});
            end
            pend_q.delete();
        end
    endtask

    task automatic send(input logic [7:0] p);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = p;
        while (!done && n < 500) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
                n++;
            end
        end
        if (done) model_accept(p);
        else check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // Monitor: compare presented word with queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", out_data);
            end else begin
                check("out_data", {7'd0, out_data}, {7'd0, exp_q[0][24:0]});
                check("out_last", {31'd0, out_last}, {31'd0, exp_q[0][25]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int bubbles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = 8'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_out_data",  {7'd0, out_data},   32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Test 1: ramp 0..63, out_ready high, latency and in_ready
        @(posedge clk); #1 out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 64; i++) send(i[7:0]);
        idle_in();
        check("lat_after_accept_edge", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_next_edge", {31'd0, out_valid}, 32'd1);
        check("t1_no_in_stall", stalls, 32'd0);
        wait_drain(200);

        // Test 2: extreme values 0,128,255 repeated
        for (int i = 0; i < 64; i++) begin
            case (i % 3)
                0:       send(8'd0);
                1:       send(8'd128);
                default: send(8'd255);
            endcase
        end
        idle_in();
        wait_drain(200);

        // Test 3: fill both banks while stalled, then drain without bubbles
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(8'((i * 7 + 3) % 256));
        @(negedge clk);
        in_pixel = 8'hAA;
        check("both_full_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("both_full_ignored", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        bubbles = 0;
        for (int i = 1; i <= 129; i++) begin
            @(negedge clk);
            if (i <= 128 && !out_valid) bubbles++;
            if (i == 64)  check("in_ready_before_release", {31'd0, in_ready}, 32'd0);
            if (i == 65)  check("in_ready_after_release",  {31'd0, in_ready}, 32'd1);
            if (i == 129) check("idle_after_two_blocks",   {31'd0, out_valid}, 32'd0);
        end
        check("no_bubble", bubbles, 32'd0);
        wait_drain(50);

        // Test 4: random out_ready toggling during input and output
        fork
            begin
                for (int i = 0; i < 64; i++) send(8'(255 - i * 3));
                idle_in();
            end
            begin
                repeat (200) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain(200);

        // Test 5: reset after a partial block, then a fresh block
        for (int i = 0; i < 30; i++) send(8'(i + 100));
        idle_in();
        rst = 1'b1;
        pend_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("partial_discarded", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 64; i++) send(8'((i * 13 + 5) % 256));
        idle_in();
        wait_drain(200);
        repeat (3) @(negedge clk);
        check("final_idle", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
